inv_sbox_table: RTL and testbench

Builds and serves the AES inverse S-box for the multicycle decryption datapath. After reset it sweeps all 256 addresses through an internal `rom_sbox` instance and writes each address into a 256×8 flop table at the location given by the forward S-box output, so that `inv[sbox(i)] = i`. An optional verify pass re-sweeps the table and flags any mismatch. Once the table is ready, InvSubBytes logic issues single-byte lookups with one-cycle latency.

---
 rtl/inv_sbox_table.sv | 109 ++++++++++
 tb/tb_inv_sbox_table.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/inv_sbox_table.sv
// Builds the AES inverse S-box in a flop table after reset (FILL, optional CHECK), then serves lookups.
// One-cycle lookup latency; no output backpressure, v_i is ignored until ready_o.

module rom_sbox (
   input  logic [7:0] rom_addr,
   output logic [7:0] data_o
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign data_o = SBOX[rom_addr];

endmodule

module inv_sbox_table #(
   parameter bit self_check_p = 1'b1
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       v_i,
   input  logic [7:0] addr_i,
   output logic       ready_o,
   output logic       busy_o,
   output logic       v_o,
   output logic [7:0] data_o,
   output logic       error_o
);

   typedef enum logic [1:0] {FILL, CHECK, READY} state_t;

   state_t     state, state_nxt;
   logic [7:0] cnt;
   logic [7:0] sb;
   logic       fill_we;
   logic       chk_en;
   logic [7:0] tbl [256];

   rom_sbox u_rom (
      .rom_addr (cnt),
      .data_o   (sb)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) state <= FILL;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (cnt == 8'hff) state_nxt = self_check_p ? CHECK : READY;
         CHECK:   if (cnt == 8'hff) state_nxt = READY;
         READY:   state_nxt = READY;
         default: state_nxt = FILL;
      endcase
   end

   always_comb begin
      ready_o = (state == READY);
      busy_o  = (state == FILL) || (state == CHECK);
      fill_we = (state == FILL);
      chk_en  = (state == CHECK);
   end

   // The counter wraps 255->0 on the FILL->CHECK handoff, so CHECK starts at 0 for free.
   always_ff @(posedge clk_i) begin
      if (reset_i)             cnt <= 8'h00;
      else if (state != READY) cnt <= cnt + 8'h01;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i && fill_we) tbl[sb] <= cnt;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)                        error_o <= 1'b0;
      else if (chk_en && (tbl[sb] != cnt)) error_o <= 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         v_o    <= 1'b0;
         data_o <= 8'h00;
      end else if (ready_o && v_i) begin
         v_o    <= 1'b1;
         data_o <= tbl[addr_i];
      end else begin
         v_o    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_inv_sbox_table.sv
// Bench for inv_sbox_table: both self_check_p settings side by side, reference S-box derived from GF(2^8) math.
module tb_inv_sbox_table;

   logic       clk = 1'b0;
   logic       reset;
   logic       v;
   logic [7:0] addr;
   logic       ready, busy, v_o, err;
   logic [7:0] data;
   logic       ready0, busy0, v_o0, err0;
   logic [7:0] data0;

   int tests = 0;
   int fails = 0;

   logic [7:0] fwd   [256];
   logic [7:0] inv_m [256];

   typedef struct {
      logic [7:0] addr;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs [5];

   always #5 clk = ~clk;

   inv_sbox_table #(.self_check_p(1'b1)) dut (
      .clk_i(clk), .reset_i(reset), .v_i(v), .addr_i(addr),
      .ready_o(ready), .busy_o(busy), .v_o(v_o), .data_o(data), .error_o(err)
   );

   inv_sbox_table #(.self_check_p(1'b0)) dut0 (
      .clk_i(clk), .reset_i(reset), .v_i(v), .addr_i(addr),
      .ready_o(ready0), .busy_o(busy0), .v_o(v_o0), .data_o(data0), .error_o(err0)
   );

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p  = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int k = 0; k < 8; k++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // Multiplicative inverse in GF(2^8) followed by the AES affine transform.
   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] b = 8'h00;
      for (int y = 1; y < 256; y++)
         if (gmul(x, 8'(y)) == 8'h01) b = 8'(y);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      int         rf, rf0;
      logic       rv;
      logic [7:0] ra, exp_d;

      vecs[0] = '{8'h63, 8'h00};
      vecs[1] = '{8'h00, 8'h52};
      vecs[2] = '{8'h7c, 8'h01};
      vecs[3] = '{8'h16, 8'hff};
      vecs[4] = '{8'h01, 8'h09};
      for (int i = 0; i < 256; i++) begin
         fwd[i] = sbox_ref(8'(i));
         inv_m[fwd[i]] = 8'(i);
      end

      reset = 1'b1; v = 1'b0; addr = 8'h00;
      tick;
      chk1("rst_ready", ready, 1'b0);
      chk1("rst_busy", busy, 1'b1);
      chk1("rst_v_o", v_o, 1'b0);
      chk8("rst_data", data, 8'h00);
      chk1("rst_err", err, 1'b0);
      chk1("rst_busy0", busy0, 1'b1);
      tick;
      tick;
      reset = 1'b0;

      // Build phase, with a request at cycle 100 that must be ignored.
      for (int c = 0; c <= 512; c++) begin
         v = (c == 100); addr = 8'h63;
         chk1("build_busy", busy, c < 512);
         chk1("build_ready", ready, c >= 512);
         chk1("build_v_o", v_o, 1'b0);
         chk1("build_busy0", busy0, c < 256);
         chk1("build_ready0", ready0, c >= 256);
         chk1("build_v_o0", v_o0, 1'b0);
         if (c < 512) tick;
      end
      chk1("build_err", err, 1'b0);
      chk1("build_err0", err0, 1'b0);

      for (int k = 0; k < 5; k++) begin
         v = 1'b1; addr = vecs[k].addr;
         tick;
         chk1("vec_v_o", v_o, 1'b1);
         chk8("vec_data", data, vecs[k].exp);
         chk8("vec_data0", data0, vecs[k].exp);
      end
      v = 1'b0;
      tick;
      chk1("vec_idle_v_o", v_o, 1'b0);
      chk8("vec_hold", data, 8'h09);

      for (int i = 0; i < 256; i++) begin
         v = 1'b1; addr = fwd[i];
         tick;
         chk1("sweep_v_o", v_o, 1'b1);
         chk8("sweep_data", data, 8'(i));
         chk8("sweep_data0", data0, 8'(i));
      end

      exp_d = 8'(255);
      for (int n = 0; n < 300; n++) begin
         rv = 1'($urandom); ra = 8'($urandom);
         v = rv; addr = ra;
         tick;
         if (rv) exp_d = inv_m[ra];
         chk1("rand_v_o", v_o, rv);
         chk8("rand_data", data, exp_d);
         chk1("rand_v_o0", v_o0, rv);
         chk8("rand_data0", data0, exp_d);
      end

      // A request coinciding with reset is dropped.
      v = 1'b1; addr = 8'h00; reset = 1'b1;
      tick;
      v = 1'b0;
      chk1("drop_v_o", v_o, 1'b0);
      chk8("drop_data", data, 8'h00);
      chk1("drop_ready", ready, 1'b0);
      reset = 1'b0;
      repeat (200) tick;
      chk1("mid_busy", busy, 1'b1);
      reset = 1'b1;
      tick;
      chk1("mid_ready", ready, 1'b0);
      chk1("mid_busy_rst", busy, 1'b1);
      reset = 1'b0;

      rf = -1; rf0 = -1;
      for (int c = 0; c < 700; c++) begin
         if (rf < 0 && ready) rf = c;
         if (rf0 < 0 && ready0) rf0 = c;
         if (rf >= 0 && rf0 >= 0) break;
         tick;
      end
      tests++;
      if (rf != 512) begin
         fails++;
         $display("FAIL rebuild_ready_cycle: got %0d expected 512", rf);
      end
      tests++;
      if (rf0 != 256) begin
         fails++;
         $display("FAIL rebuild_ready0_cycle: got %0d expected 256", rf0);
      end

      v = 1'b1; addr = 8'h00;
      tick;
      chk1("post_v_o", v_o, 1'b1);
      chk8("post_data", data, 8'h52);
      chk8("post_data0", data0, 8'h52);
      v = 1'b1; addr = 8'h16;
      tick;
      chk8("post_data_16", data, 8'hff);
      chk8("post_data0_16", data0, 8'hff);
      v = 1'b0;
      tick;
      chk1("post_idle", v_o, 1'b0);
      chk1("post_err", err, 1'b0);
      chk1("post_err0", err0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
